// File: rtl/risc_v.sv
// RV32I-subset five-stage in-order core (IF/ID/EX/MA/WB) with internal instruction and data memories.
// The instruction memory image is placed in i_mem by the surrounding environment; regfile and d_mem survive reset.
module risc_v_ma #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] d_mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) d_mem[idx_i] <= wdata_i;
  end

  assign rdata_o = d_mem[idx_i];
endmodule

module risc_v #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input logic clk1,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LD  = 7'b0000011;
  localparam logic [6:0]  OP_ST  = 7'b0100011;
  localparam logic [6:0]  OP_BR  = 7'b1100011;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_LUI = 7'b0110111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        alt;
    logic        use_imm;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        jal;
    logic        lui;
  } idex_t;

  logic [31:0] i_mem   [0:IMEM_DEPTH-1];
  logic [31:0] regfile [0:31];

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_instr_q;
  idex_t       idex_q, idex_d;
  logic [31:0] exma_res_q, exma_b_q;
  logic [4:0]  exma_rd_q;
  logic        exma_we_q, exma_mrd_q, exma_mwr_q;
  logic [31:0] mawb_res_q;
  logic [4:0]  mawb_rd_q;
  logic        mawb_we_q;

  // ---------------- ID: decode, register read with WB bypass
  logic [31:0] id_in;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_f3;
  logic        id_use_rs1, id_use_rs2, load_use;
  logic [31:0] id_a, id_b;

  assign id_in  = ifid_instr_q;
  assign id_rs1 = id_in[19:15];
  assign id_rs2 = id_in[24:20];
  assign id_rd  = id_in[11:7];
  assign id_f3  = id_in[14:12];

  assign id_a = (id_rs1 == 5'd0) ? 32'd0 :
                (mawb_we_q && mawb_rd_q == id_rs1) ? mawb_res_q : regfile[id_rs1];
  assign id_b = (id_rs2 == 5'd0) ? 32'd0 :
                (mawb_we_q && mawb_rd_q == id_rs2) ? mawb_res_q : regfile[id_rs2];

  always_comb begin
    idex_d     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    idex_d.pc  = ifid_pc_q;
    idex_d.a   = id_a;
    idex_d.b   = id_b;
    idex_d.rs1 = id_rs1;
    idex_d.rs2 = id_rs2;
    idex_d.rd  = id_rd;
    case (id_in[6:0])
      OP_R: begin
        idex_d.we = 1'b1; idex_d.f3 = id_f3; idex_d.alt = id_in[30];
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      end
      OP_I: begin
        idex_d.we = 1'b1; idex_d.f3 = id_f3; idex_d.alt = (id_f3 == 3'd5) && id_in[30];
        idex_d.use_imm = 1'b1; idex_d.imm = {{20{id_in[31]}}, id_in[31:20]};
        id_use_rs1 = 1'b1;
      end
      OP_LD: begin
        idex_d.we = 1'b1; idex_d.mrd = 1'b1; idex_d.use_imm = 1'b1;
        idex_d.imm = {{20{id_in[31]}}, id_in[31:20]};
        id_use_rs1 = 1'b1;
      end
      OP_ST: begin
        idex_d.mwr = 1'b1; idex_d.use_imm = 1'b1;
        idex_d.imm = {{20{id_in[31]}}, id_in[31:25], id_in[11:7]};
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      end
      OP_BR: begin
        idex_d.br = (id_f3 == 3'd0) || (id_f3 == 3'd1) || (id_f3 == 3'd4) || (id_f3 == 3'd5);
        idex_d.f3 = id_f3;
        idex_d.imm = {{19{id_in[31]}}, id_in[31], id_in[7], id_in[30:25], id_in[11:8], 1'b0};
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        idex_d.we = 1'b1; idex_d.jal = 1'b1;
        idex_d.imm = {{11{id_in[31]}}, id_in[31], id_in[19:12], id_in[20], id_in[30:21], 1'b0};
      end
      OP_LUI: begin
        idex_d.we = 1'b1; idex_d.lui = 1'b1; idex_d.imm = {id_in[31:12], 12'd0};
      end
      default: ;
    endcase
  end

  // A load's data only exists in MA, so a consumer right behind it waits one cycle.
  assign load_use = idex_q.mrd && (idex_q.rd != 5'd0) &&
                    ((id_use_rs1 && idex_q.rd == id_rs1) || (id_use_rs2 && idex_q.rd == id_rs2));

  // ---------------- EX: forwarding (EX/MA is younger than MA/WB), ALU, branch resolve
  logic [31:0] ex_a, ex_b, ex_op2, ex_alu, ex_res, ex_target;
  logic        ex_cond, ex_taken;

  assign ex_a = (exma_we_q && exma_rd_q != 5'd0 && exma_rd_q == idex_q.rs1) ? exma_res_q :
                (mawb_we_q && mawb_rd_q != 5'd0 && mawb_rd_q == idex_q.rs1) ? mawb_res_q : idex_q.a;
  assign ex_b = (exma_we_q && exma_rd_q != 5'd0 && exma_rd_q == idex_q.rs2) ? exma_res_q :
                (mawb_we_q && mawb_rd_q != 5'd0 && mawb_rd_q == idex_q.rs2) ? mawb_res_q : idex_q.b;
  assign ex_op2 = idex_q.use_imm ? idex_q.imm : ex_b;

  always_comb begin
    ex_alu = 32'd0;
    case (idex_q.f3)
      3'd0: ex_alu = idex_q.alt ? ex_a - ex_op2 : ex_a + ex_op2;
      3'd1: ex_alu = ex_a << ex_op2[4:0];
      3'd2: ex_alu = {31'd0, $signed(ex_a) < $signed(ex_op2)};
      3'd3: ex_alu = {31'd0, ex_a < ex_op2};
      3'd4: ex_alu = ex_a ^ ex_op2;
      3'd5: ex_alu = idex_q.alt ? 32'($signed(ex_a) >>> ex_op2[4:0]) : ex_a >> ex_op2[4:0];
      3'd6: ex_alu = ex_a | ex_op2;
      default: ex_alu = ex_a & ex_op2;
    endcase
  end

  always_comb begin
    ex_cond = 1'b0;
    case (idex_q.f3)
      3'd0: ex_cond = (ex_a == ex_b);
      3'd1: ex_cond = (ex_a != ex_b);
      3'd4: ex_cond = ($signed(ex_a) < $signed(ex_b));
      3'd5: ex_cond = ($signed(ex_a) >= $signed(ex_b));
      default: ex_cond = 1'b0;
    endcase
  end

  assign ex_res    = idex_q.jal ? idex_q.pc + 32'd4 : (idex_q.lui ? idex_q.imm : ex_alu);
  assign ex_taken  = idex_q.jal || (idex_q.br && ex_cond);
  assign ex_target = idex_q.pc + idex_q.imm;

  // ---------------- IF: next PC
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (ex_taken)      pc_d = ex_target;
    else if (load_use) pc_d = pc_q;
  end

  // ---------------- MA
  logic [31:0] ma_rdata, ma_res;

  risc_v_ma #(.DEPTH(DMEM_DEPTH), .AW(DAW)) ma_module (
    .clk_i   (clk1),
    .we_i    (exma_mwr_q),
    .idx_i   (exma_res_q[DAW+1:2]),
    .wdata_i (exma_b_q),
    .rdata_o (ma_rdata)
  );

  assign ma_res = exma_mrd_q ? ma_rdata : exma_res_q;

  // ---------------- pipeline registers
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      pc_q         <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP;
      idex_q       <= '0;
      exma_res_q   <= 32'd0;
      exma_b_q     <= 32'd0;
      exma_rd_q    <= 5'd0;
      exma_we_q    <= 1'b0;
      exma_mrd_q   <= 1'b0;
      exma_mwr_q   <= 1'b0;
      mawb_res_q   <= 32'd0;
      mawb_rd_q    <= 5'd0;
      mawb_we_q    <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (ex_taken) begin
        ifid_pc_q    <= 32'd0;
        ifid_instr_q <= NOP;
      end else if (!load_use) begin
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= i_mem[pc_q[IAW+1:2]];
      end
      idex_q     <= (ex_taken || load_use) ? '0 : idex_d;
      exma_res_q <= ex_res;
      exma_b_q   <= ex_b;
      exma_rd_q  <= idex_q.rd;
      exma_we_q  <= idex_q.we;
      exma_mrd_q <= idex_q.mrd;
      exma_mwr_q <= idex_q.mwr;
      mawb_res_q <= ma_res;
      mawb_rd_q  <= exma_rd_q;
      mawb_we_q  <= exma_we_q;
    end
  end

  // ---------------- WB: architectural register file, deliberately outside reset
  always_ff @(posedge clk1) begin
    if (mawb_we_q && mawb_rd_q != 5'd0) regfile[mawb_rd_q] <= mawb_res_q;
  end
endmodule

// File: tb/tb_risc_v.sv
// Directed bench for risc_v: two small programs with hand-computed register and memory results,
// separated by a mid-run reset that must keep regfile and d_mem contents.
module tb_risc_v;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q[$];
  int          reg_q[$];

  always #5 clk1 = ~clk1;

  risc_v dut (
    .clk1 (clk1),
    .rst  (rst)
  );

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd);
    return {imm20[19:0], rd[4:0], 7'h37};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic expect_reg(input int r, input logic [31:0] val);
    reg_q.push_back(r);
    exp_q.push_back(val);
  endtask

  task automatic drain_regs(input string phase);
    int r;
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      r = reg_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("%s_x%0d", phase, r), dut.regfile[r], e);
    end
  endtask

  initial begin
    // ---- preload memories, program A
    for (int i = 0; i < 1024; i++) begin
      dut.i_mem[i] = 32'h0;
      dut.ma_module.d_mem[i] <= 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.regfile[i] <= 32'h0;
    dut.regfile[26] <= 32'habcdef12;

    dut.i_mem[0]  = enc_i(3, 0, 0, 5, 32'h13);          // addi x5,x0,3
    dut.i_mem[1]  = enc_b(8, 5, 5, 0);                  // beq  x5,x5,+8
    dut.i_mem[2]  = enc_i(1, 0, 0, 6, 32'h13);          // addi x6,x0,1 (flushed)
    dut.i_mem[3]  = enc_i(2, 0, 0, 7, 32'h13);          // addi x7,x0,2
    dut.i_mem[4]  = enc_j(8, 1);                        // jal  x1,+8 at 0x10
    dut.i_mem[5]  = enc_i(99, 0, 0, 9, 32'h13);         // addi x9,x0,99 (skipped)
    dut.i_mem[6]  = enc_i(9, 0, 0, 0, 32'h13);          // addi x0,x0,9
    dut.i_mem[7]  = enc_r(32'h20, 5, 0, 0, 8);          // sub  x8,x0,x5
    dut.i_mem[8]  = enc_b(8, 5, 5, 1);                  // bne  x5,x5,+8 (not taken)
    dut.i_mem[9]  = enc_i(1, 0, 0, 10, 32'h13);         // addi x10,x0,1
    dut.i_mem[10] = enc_b(8, 5, 8, 4);                  // blt  x8,x5,+8 (taken)
    dut.i_mem[11] = enc_i(1, 0, 0, 11, 32'h13);         // addi x11,x0,1 (skipped)
    dut.i_mem[12] = enc_b(8, 5, 8, 5);                  // bge  x8,x5,+8 (not taken)
    dut.i_mem[13] = enc_i(4, 0, 0, 12, 32'h13);         // addi x12,x0,4
    dut.i_mem[14] = enc_u(32'h12345, 13);               // lui  x13,0x12345

    // ---- reset pulse 1..2 ns
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    #1 check("pc_after_reset", dut.pc_q, 32'h0);

    repeat (4) @(posedge clk1);
    #1 check("no_wb_before_5th_edge", dut.regfile[5], 32'h0);
    @(posedge clk1);
    #1 check("first_wb_at_5th_edge", dut.regfile[5], 32'h3);

    repeat (30) @(posedge clk1);
    #1;
    expect_reg(5,  32'h0000_0003);
    expect_reg(6,  32'h0000_0000);
    expect_reg(7,  32'h0000_0002);
    expect_reg(1,  32'h0000_0014);
    expect_reg(9,  32'h0000_0000);
    expect_reg(0,  32'h0000_0000);
    expect_reg(8,  32'hffff_fffd);
    expect_reg(10, 32'h0000_0001);
    expect_reg(11, 32'h0000_0000);
    expect_reg(12, 32'h0000_0004);
    expect_reg(13, 32'h1234_5000);
    drain_regs("progA");

    // ---- mid-run asynchronous reset, load program B while held
    #2 rst = 1'b0;
    #1;
    check("pc_mid_reset", dut.pc_q, 32'h0);
    check("exma_we_mid_reset", {31'd0, dut.exma_we_q}, 32'h0);
    check("mawb_we_mid_reset", {31'd0, dut.mawb_we_q}, 32'h0);
    for (int i = 0; i < 16; i++) dut.i_mem[i] = 32'h0;
    dut.i_mem[0]  = enc_i(5, 0, 0, 5, 32'h13);          // addi x5,x0,5
    dut.i_mem[1]  = enc_i(7, 0, 0, 6, 32'h13);          // addi x6,x0,7
    dut.i_mem[2]  = enc_r(0, 6, 5, 0, 7);               // add  x7,x5,x6
    dut.i_mem[3]  = enc_s(8, 26, 0);                    // sw   x26,8(x0)
    dut.i_mem[4]  = enc_i(8, 0, 2, 28, 32'h03);         // lw   x28,8(x0)
    dut.i_mem[5]  = enc_i(1, 28, 0, 29, 32'h13);        // addi x29,x28,1
    dut.i_mem[6]  = enc_r(0, 8, 5, 3, 14);              // sltu x14,x5,x8
    dut.i_mem[7]  = enc_r(0, 5, 8, 2, 15);              // slt  x15,x8,x5
    dut.i_mem[8]  = enc_i(32'h401, 8, 5, 16, 32'h13);   // srai x16,x8,1
    dut.i_mem[9]  = enc_i(28, 8, 5, 17, 32'h13);        // srli x17,x8,28
    dut.i_mem[10] = enc_r(0, 6, 5, 4, 18);              // xor  x18,x5,x6
    dut.i_mem[11] = enc_r(0, 5, 6, 1, 19);              // sll  x19,x6,x5
    #3 rst = 1'b1;

    repeat (40) @(posedge clk1);
    #1;
    check("dmem_word2", dut.ma_module.d_mem[2], 32'habcdef12);
    expect_reg(7,  32'h0000_000c);
    expect_reg(28, 32'habcd_ef12);
    expect_reg(29, 32'habcd_ef13);
    expect_reg(26, 32'habcd_ef12);
    expect_reg(8,  32'hffff_fffd);
    expect_reg(14, 32'h0000_0001);
    expect_reg(15, 32'h0000_0001);
    expect_reg(16, 32'hffff_fffe);
    expect_reg(17, 32'h0000_000f);
    expect_reg(18, 32'h0000_0002);
    expect_reg(19, 32'h0000_00e0);
    expect_reg(0,  32'h0000_0000);
    drain_regs("progB");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
